// File: rtl/apb_counter_slave.sv
// APB3 slave wrapping a 32-bit up/down timer with terminal-count status and interrupt.
// Register map: CTRL 0x00, LOAD 0x04, COUNT 0x08, STATUS 0x0C (TC, write-1-to-clear).
module apb_counter_slave #(
  parameter int WAIT_STATES = 0
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic [31:0] PADDR,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic        irq
);

  localparam logic [3:0] LP_WAIT   = 4'(WAIT_STATES);
  localparam int         CTRL_EN   = 0;
  localparam int         CTRL_DIR  = 1;
  localparam int         CTRL_AUTO = 2;
  localparam int         CTRL_IRQ  = 3;

  logic [3:0]  r_ctrl;
  logic [31:0] r_load;
  logic [31:0] r_count;
  logic        r_tc;
  logic [3:0]  r_wait_cnt;

  logic        w_access;
  logic        w_ready;
  logic        w_addr_err;
  logic        w_sel_ctrl;
  logic        w_sel_load;
  logic        w_sel_count;
  logic        w_sel_status;
  logic [31:0] w_rd_data;
  logic        w_wr;
  logic        w_wr_ctrl;
  logic        w_wr_load;
  logic        w_wr_count;
  logic        w_wr_status;
  logic [31:0] w_count_nxt;
  logic        w_tc_hit;
  logic        w_en_clr;
  logic [3:0]  w_ctrl_nxt;
  logic        w_tc_nxt;
  logic        w_unused;

  assign w_unused = ^PADDR[31:5];

  // Reset gates completion so a transfer caught by PRESET is abandoned outright.
  assign w_access = PSEL & PENABLE;
  assign w_ready  = w_access & ~PRESET & (r_wait_cnt == LP_WAIT);

  // Address decode and read mux.
  always_comb begin
    w_addr_err   = 1'b0;
    w_sel_ctrl   = 1'b0;
    w_sel_load   = 1'b0;
    w_sel_count  = 1'b0;
    w_sel_status = 1'b0;
    w_rd_data    = 32'h0000_0000;
    case (PADDR[4:0])
      5'h00: begin
        w_sel_ctrl = 1'b1;
        w_rd_data  = {28'h000_0000, r_ctrl};
      end
      5'h04: begin
        w_sel_load = 1'b1;
        w_rd_data  = r_load;
      end
      5'h08: begin
        w_sel_count = 1'b1;
        w_rd_data   = r_count;
      end
      5'h0C: begin
        w_sel_status = 1'b1;
        w_rd_data    = {31'h0000_0000, r_tc};
      end
      default: begin
        w_addr_err = 1'b1;
      end
    endcase
  end

  assign w_wr        = w_ready & PWRITE & ~w_addr_err;
  assign w_wr_ctrl   = w_wr & w_sel_ctrl;
  assign w_wr_load   = w_wr & w_sel_load;
  assign w_wr_count  = w_wr & w_sel_count;
  assign w_wr_status = w_wr & w_sel_status;

  assign PREADY  = w_ready;
  assign PSLVERR = w_ready & w_addr_err;
  assign PRDATA  = (w_ready & ~PWRITE & ~w_addr_err) ? w_rd_data : 32'h0000_0000;
  assign irq     = r_tc & r_ctrl[CTRL_IRQ];

  // Counter next-state; a COUNT write replaces the step and suppresses terminal-count.
  always_comb begin
    w_count_nxt = r_count;
    w_tc_hit    = 1'b0;
    w_en_clr    = 1'b0;
    if (w_wr_count) begin
      w_count_nxt = PWDATA;
    end else if (r_ctrl[CTRL_EN]) begin
      if (!r_ctrl[CTRL_DIR]) begin
        if (r_count == r_load) begin
          w_tc_hit = 1'b1;
          if (r_ctrl[CTRL_AUTO]) begin
            w_count_nxt = 32'h0000_0000;
          end else begin
            w_en_clr = 1'b1;
          end
        end else begin
          w_count_nxt = r_count + 32'd1;
        end
      end else begin
        if (r_count == 32'h0000_0000) begin
          w_tc_hit = 1'b1;
          if (r_ctrl[CTRL_AUTO]) begin
            w_count_nxt = r_load;
          end else begin
            w_en_clr = 1'b1;
          end
        end else begin
          w_count_nxt = r_count - 32'd1;
        end
      end
    end else begin
      w_count_nxt = r_count;
    end
  end

  // CTRL and STATUS next-state: software CTRL write beats the one-shot EN clear,
  // hardware TC set beats the W1C.
  always_comb begin
    w_ctrl_nxt = r_ctrl;
    w_tc_nxt   = r_tc;
    if (w_wr_ctrl) begin
      w_ctrl_nxt = PWDATA[3:0];
    end else if (w_en_clr) begin
      w_ctrl_nxt = {r_ctrl[3:1], 1'b0};
    end else begin
      w_ctrl_nxt = r_ctrl;
    end
    if (w_tc_hit) begin
      w_tc_nxt = 1'b1;
    end else if (w_wr_status && PWDATA[0]) begin
      w_tc_nxt = 1'b0;
    end else begin
      w_tc_nxt = r_tc;
    end
  end

  // Access-phase wait counter, cleared on completion or abort.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_wait_cnt <= 4'h0;
    end else if (!w_access || w_ready) begin
      r_wait_cnt <= 4'h0;
    end else begin
      r_wait_cnt <= r_wait_cnt + 4'd1;
    end
  end

  // Register file update.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_ctrl  <= 4'h0;
      r_load  <= 32'h0000_0000;
      r_count <= 32'h0000_0000;
      r_tc    <= 1'b0;
    end else begin
      r_ctrl  <= w_ctrl_nxt;
      r_load  <= w_wr_load ? PWDATA : r_load;
      r_count <= w_count_nxt;
      r_tc    <= w_tc_nxt;
    end
  end

endmodule

// File: doc/apb_counter_slave.md
APB_COUNTER_SLAVE -- requirements
Module: apb_counter_slave

Interface
REQ-001 SHALL have parameter WAIT_STATES, default 0, range 0..15: number of access-phase cycles with PREADY held low before completion.
REQ-002 SHALL have port PCLK, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port PRESET, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port PADDR, input, 32: byte address; only PADDR[4:0] is decoded, upper bits ignored.
REQ-005 SHALL have ports PSEL, PENABLE and PWRITE, each input, 1: APB select, access-phase strobe and write flag.
REQ-006 SHALL have port PWDATA, input, 32: write data.
REQ-007 SHALL have port PRDATA, output, 32: read data.
REQ-008 SHALL have port PREADY, output, 1: transfer completion.
REQ-009 SHALL have port PSLVERR, output, 1: error response, valid only while PREADY is high.
REQ-010 SHALL have port irq, output, 1: level interrupt, equal to STATUS.TC AND CTRL.IRQ_EN.

Function
REQ-011 SHALL decode the register map: 0x00 CTRL (bit0 EN, bit1 DIR where 0=up and 1=down, bit2 AUTO_RELOAD, bit3 IRQ_EN, other bits read 0); 0x04 LOAD (32b); 0x08 COUNT (32b); 0x0C STATUS (bit0 TC, write-1-to-clear).
REQ-012 SHALL treat any other offset (0x10-0x1F) or PADDR[1:0]!=0 as an error: PSLVERR=1 with PREADY, writes ignored, PRDATA=0.
REQ-013 SHALL treat PSEL=1 with PENABLE=0 as the setup phase, and PSEL=1 with PENABLE=1 as the access phase.
REQ-014 SHALL count wait cycles in the access phase: PREADY=0 for the first WAIT_STATES access cycles, then PREADY=1 for exactly one cycle; with WAIT_STATES=0, PREADY=1 on the first access cycle.
REQ-015 SHALL drive PREADY=0, PSLVERR=0 and PRDATA=0 outside the completing access cycle.
REQ-016 SHALL clear the wait counter on completion, and whenever PSEL=0 or PENABLE=0 (aborted transfer).
REQ-017 SHALL commit a write on the rising edge that ends the completing cycle (PSEL & PENABLE & PREADY & PWRITE); the new value is visible to a read in the next transfer.
REQ-018 SHALL drive PRDATA in the completing read cycle with the register value current in that cycle (COUNT read is not stalled by counting).
REQ-019 SHALL leave COUNT unchanged while CTRL.EN=0.
REQ-020 SHALL, up mode (EN=1, DIR=0), increment COUNT by 1 per cycle while COUNT!=LOAD.
REQ-021 SHALL, up mode at COUNT==LOAD: set TC, and then set COUNT<=0 if AUTO_RELOAD=1, else hold COUNT and clear EN.
REQ-022 SHALL, down mode (EN=1, DIR=1), decrement COUNT by 1 per cycle while COUNT!=0.
REQ-023 SHALL, down mode at COUNT==0: set TC, and then set COUNT<=LOAD if AUTO_RELOAD=1, else hold COUNT and clear EN.
REQ-024 SHALL use 32-bit modulo arithmetic for COUNT; no wrap occurs except through REQ-021/023 (COUNT>LOAD in up mode increments through 0xFFFFFFFF to 0 and continues).
REQ-025 SHALL give an APB write to COUNT priority over counting in the same cycle; no TC is evaluated that cycle.
REQ-026 SHALL give an APB write to CTRL priority over the hardware EN clear in the same cycle.
REQ-027 SHALL let a hardware TC set win over a same-cycle STATUS W1C write.
REQ-028 SHALL make irq combinational from the registered TC and IRQ_EN, with no extra latency.

Reset
REQ-029 SHALL, with PRESET=1 at a PCLK edge, set CTRL, LOAD, COUNT, STATUS and the wait counter to 0; PREADY, PSLVERR, PRDATA and irq read 0 in the following cycle.
REQ-030 SHALL, when PRESET is asserted mid-transfer, abandon the transfer with no register update; PRESET overrides all APB and counting activity.

Verification
REQ-031 Reset: PRESET high 2 cycles, then read all 4 registers -> each reads 0, PSLVERR=0.
REQ-032 Up auto-reload: LOAD=3, CTRL=0x5 -> COUNT sequence 0,1,2,3,0,1...; TC=1 after first 3; W1C STATUS=1 -> TC=0.
REQ-033 Down one-shot with irq: LOAD=2, COUNT=2, CTRL=0xA then 0xB -> COUNT 2,1,0 then holds 0; EN reads 0; irq=1 until STATUS written 0x1.
REQ-034 Wait states (WAIT_STATES=3): write LOAD=0x1234 -> PREADY low 3 access cycles, high on 4th; read back 0x1234.
REQ-035 Error: read 0x10 and write 0x06 -> PSLVERR=1 with PREADY, PRDATA=0, no register change.
REQ-036 Collisions: COUNT write of 0x100 in the same cycle as an increment -> COUNT=0x100; W1C in the same cycle as TC set -> TC remains 1.
